// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioning path.
// Imported by the conditioner, its per-channel debouncer and the game logic.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_WAIT = 2'b10
    } btn_state_e;

    localparam int unsigned NUM_BTN = 4;

    localparam int unsigned BTN_N = 3;
    localparam int unsigned BTN_S = 2;
    localparam int unsigned BTN_W = 1;
    localparam int unsigned BTN_E = 0;

    // Width big enough to hold the largest of the three cycle counts.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the paddle logic.
// master drives the raw buttons and consumes the conditioned outputs.
interface button_conditioner_if;
    import btn_pkg::*;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_debounce_channel.sv
// One button: two-flop synchroniser, debounce FSM and auto-repeat counter.
// All outputs are registered; press and release never pulse together.
module button_debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam bit REP_EN = (REPEAT_DELAY != 0);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REP_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD != 0 ? REPEAT_PERIOD - 1 : 0);

    logic [1:0]    sync;
    logic          s;
    btn_state_e    state;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] rcnt;
    logic          rep_first;
    logic          held;
    logic          rel_accept;
    logic          rep_tick;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) sync <= 2'b00;
        else        sync <= {sync[0], raw};
    end

    assign s = sync[1];

    always_comb begin
        held       = (state == PRESSED) || (state == RELEASE_WAIT);
        rel_accept = (state == RELEASE_WAIT) && !s && (dcnt == DB_LAST);
        rep_tick   = REP_EN && held && (rcnt == (rep_first ? RD_LAST : RP_LAST));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            dcnt      <= '0;
            rcnt      <= '0;
            rep_first <= 1'b1;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            unique case (state)
                IDLE: begin
                    dcnt <= '0;
                    if (s) state <= PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == DB_LAST) begin
                        state     <= PRESSED;
                        dcnt      <= '0;
                        level     <= 1'b1;
                        press     <= 1'b1;
                        rcnt      <= '0;
                        rep_first <= 1'b1;
                    end else if (dcnt != '1) begin
                        dcnt <= dcnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                        dcnt  <= '0;
                    end else if (rel_accept) begin
                        state <= IDLE;
                        dcnt  <= '0;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else if (dcnt != '1) begin
                        dcnt <= dcnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Repeat keeps running through a release bounce; a release wins a tie.
            if (REP_EN && held) begin
                if (rep_tick) begin
                    rcnt      <= '0;
                    rep_first <= 1'b0;
                    if (!rel_accept) press <= 1'b1;
                end else if (rcnt != '1) begin
                    rcnt <= rcnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounced button channels feeding the paddle/ball logic.
// Runs on the pixel clock; reset is asynchronous and active low.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    button_conditioner_if.slave  btn
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .Clock (Clock),
            .Reset (Reset),
            .raw   (btn.btn_raw[i]),
            .level (btn.btn_level[i]),
            .press (btn.btn_press[i]),
            .rel   (btn.btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat settings,
// plus a second instance with auto-repeat disabled.
module tb_button_conditioner;
    import btn_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    string step = "init";

    button_conditioner_if bus ();
    button_conditioner_if bus_nr ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .btn   (bus)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (0),
        .REPEAT_PERIOD   (5)
    ) dut_nr (
        .Clock (Clock),
        .Reset (Reset),
        .btn   (bus_nr)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic check_outs(input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rls);
        check("level",   32'(bus.btn_level),   32'(lvl));
        check("press",   32'(bus.btn_press),   32'(prs));
        check("release", 32'(bus.btn_release), 32'(rls));
    endtask

    // Advance one edge, then compare all outputs one time unit later.
    task automatic tick(input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rls);
        @(posedge Clock);
        #1;
        check_outs(lvl, prs, rls);
    endtask

    task automatic hold(input int n, input logic [3:0] lvl);
        for (int k = 0; k < n; k++) tick(lvl, 4'b0000, 4'b0000);
    endtask

    initial begin
        int np, nr, first;
        bus.btn_raw    = 4'b0000;
        bus_nr.btn_raw = 4'b0000;

        #1 Reset = 1'b0;
        #2;
        step = "reset";
        check_outs(4'b0000, 4'b0000, 4'b0000);
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b1;
        hold(2, 4'b0000);

        // Clean press of NORTH for 30 cycles; last repeat collides with release.
        step = "clean";
        bus.btn_raw[BTN_N] = 1'b1;
        hold(6, 4'b0000);
        tick(4'b1000, 4'b1000, 4'b0000);
        hold(9, 4'b1000);
        tick(4'b1000, 4'b1000, 4'b0000);
        hold(4, 4'b1000);
        tick(4'b1000, 4'b1000, 4'b0000);
        hold(4, 4'b1000);
        tick(4'b1000, 4'b1000, 4'b0000);
        hold(3, 4'b1000);
        bus.btn_raw[BTN_N] = 1'b0;
        hold(1, 4'b1000);
        tick(4'b1000, 4'b1000, 4'b0000);
        hold(4, 4'b1000);
        tick(4'b0000, 4'b0000, 4'b1000);
        hold(3, 4'b0000);

        // EAST bounces with 3-cycle phases, then holds.
        step = "bounce";
        bus.btn_raw[BTN_E] = 1'b1; hold(3, 4'b0000);
        bus.btn_raw[BTN_E] = 1'b0; hold(3, 4'b0000);
        bus.btn_raw[BTN_E] = 1'b1; hold(3, 4'b0000);
        bus.btn_raw[BTN_E] = 1'b0; hold(3, 4'b0000);
        bus.btn_raw[BTN_E] = 1'b1;
        hold(6, 4'b0000);
        tick(4'b0001, 4'b0001, 4'b0000);
        hold(9, 4'b0001);
        tick(4'b0001, 4'b0001, 4'b0000);

        // 2-cycle low glitch while held: no release, repeats stay on schedule.
        step = "rel_bounce";
        hold(1, 4'b0001);
        bus.btn_raw[BTN_E] = 1'b0;
        hold(2, 4'b0001);
        bus.btn_raw[BTN_E] = 1'b1;
        hold(1, 4'b0001);
        tick(4'b0001, 4'b0001, 4'b0000);
        hold(4, 4'b0001);
        tick(4'b0001, 4'b0001, 4'b0000);
        bus.btn_raw[BTN_E] = 1'b0;
        hold(4, 4'b0001);
        tick(4'b0001, 4'b0001, 4'b0000);
        hold(1, 4'b0001);
        tick(4'b0000, 4'b0000, 4'b0001);
        hold(3, 4'b0000);

        step = "all4";
        bus.btn_raw = 4'b1111;
        hold(6, 4'b0000);
        tick(4'b1111, 4'b1111, 4'b0000);
        bus.btn_raw = 4'b0000;
        hold(6, 4'b1111);
        tick(4'b0000, 4'b0000, 4'b1111);
        hold(2, 4'b0000);

        // Reset while WEST is held: outputs clear at once, no release pulse.
        step = "reset_mid";
        bus.btn_raw[BTN_W] = 1'b1;
        hold(6, 4'b0000);
        tick(4'b0010, 4'b0010, 4'b0000);
        hold(3, 4'b0010);
        Reset = 1'b0;
        #1;
        check_outs(4'b0000, 4'b0000, 4'b0000);
        hold(2, 4'b0000);
        Reset = 1'b1;
        hold(6, 4'b0000);
        tick(4'b0010, 4'b0010, 4'b0000);
        bus.btn_raw[BTN_W] = 1'b0;
        hold(6, 4'b0010);
        tick(4'b0000, 4'b0000, 4'b0010);

        // Auto-repeat disabled: 100 held cycles give a single press.
        step = "no_repeat";
        np = 0; nr = 0; first = -1;
        bus_nr.btn_raw[BTN_S] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clock);
            #1;
            if (bus_nr.btn_press != 4'b0000) begin
                np++;
                if (first < 0) first = i;
            end
            if (bus_nr.btn_release != 4'b0000) nr++;
        end
        check("press_count",   32'(np), 32'd1);
        check("first_press",   32'(first), 32'd6);
        check("release_count", 32'(nr), 32'd0);
        check("level",         32'(bus_nr.btn_level), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
